mc_bus_responder: RTL and testbench
===================================

MC_BUS_RESPONDER -- requirements
Module: mc_bus_responder

Interface
REQ-001 SHALL have parameter MC_DATA_WIDTH, default 16, meaning data bus and register width.
REQ-002 SHALL have parameter MC_ADD_WIDTH, default 6, meaning address bus width.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mc_ce  input  1  MCU chip enable, active low, asynchronous to clock.
REQ-006 SHALL have port mc_we  input  1  MCU write strobe, active low, asynchronous.
REQ-007 SHALL have port mc_oe  input  1  MCU read strobe, active low, asynchronous.
REQ-008 SHALL have port mc_add  input  MC_ADD_WIDTH  MCU address.
REQ-009 SHALL have port mc_data_i  input  MC_DATA_WIDTH  MCU write data from the pad buffer.
REQ-010 SHALL have port mc_data_o  output  MC_DATA_WIDTH  read data to the pad buffer.
REQ-011 SHALL have port mc_data_oe  output  1  high = FPGA drives mc_data.
REQ-012 SHALL have port cfg_regs  output  7*MC_DATA_WIDTH  registers 0x00-0x06; register n at bits [n*W+W-1:n*W].
REQ-013 SHALL have ports cmd_data (output, W), cmd_valid (output, 1), cmd_ready (input, 1)  command stream out.
REQ-014 SHALL have ports rsp_data (input, W), rsp_valid (input, 1), rsp_ready (output, 1)  response stream in.

Function
REQ-015 SHALL pass mc_ce, mc_we, mc_oe, mc_add and mc_data_i each through a 2-flop synchronizer before any use.
REQ-016 SHALL generate a write strobe for one cycle when synchronized mc_we goes 1->0 while synchronized mc_ce is 0.
REQ-017 SHALL perform the write action in the cycle after the strobe, using synchronized address and data captured at the strobe (3 clocks after pin mc_we falls).
REQ-018 Addresses 0x00-0x06: write SHALL load the addressed cfg_regs word.
REQ-019 Address 0x07: write SHALL load cmd_data and assert cmd_valid; cmd_valid SHALL clear on the cycle cmd_valid && cmd_ready.
REQ-020 Address 0x07 write while cmd_valid is still high SHALL discard the new word, keep the pending one, and set sticky flag ovf.
REQ-021 Address 0x09: write SHALL clear ovf and unf, regardless of data.
REQ-022 Writes to any other address SHALL be ignored.
REQ-023 mc_data_oe SHALL be registered and equal 1 exactly while synchronized mc_ce=0 and mc_oe=0.
REQ-024 mc_data_o SHALL be a registered mux: 0x00-0x06 cfg word; 0x07 cmd_data; 0x08 rsp_data if rsp_valid else 0; 0x09 {W-4 zeros, ovf, unf, cmd_valid, rsp_valid}; other addresses 0.
REQ-025 On synchronized mc_oe 0->1 with mc_ce=0 and address 0x08: if rsp_valid, SHALL pulse rsp_ready for exactly one cycle (pop); else SHALL set sticky unf.
REQ-026 rsp_ready SHALL never assert except per REQ-025; one pop per read strobe.
REQ-027 Simultaneous mc_we and mc_oe low SHALL be treated as a write only; no pop, mc_data_oe forced 0.
REQ-028 Synchronized mc_ce rising mid-access SHALL drop mc_data_oe next cycle and suppress pending pop/write.
REQ-029 The write path (including ovf set) SHALL take precedence over the 0x09 clear in the same cycle.

Reset
REQ-030 On reset SHALL clear all cfg_regs, cmd_data, cmd_valid, rsp_ready, mc_data_o, mc_data_oe, ovf, unf and synchronizer flops, with synchronizers reset to the idle level (ce, we, oe = 1).
REQ-031 Reset asserted mid-transaction SHALL abort it; the first strobe after reset release SHALL require a fresh 1->0 edge.

Verification
REQ-032 Write 0x00=0x00FB, 0x01=0x0004, 0x03=0x0080 (we low 6 clocks each) -> cfg_regs words 0/1/3 = 0x00FB/0x0004/0x0080, others 0.
REQ-033 Write 0x07=0x08AA with cmd_ready=1 -> cmd_valid high exactly 1 cycle, cmd_data=0x08AA, 3 clocks after we fall.
REQ-034 cmd_ready=0, write 0x07=0x08AA then 0x07=0x08FF -> cmd_data stays 0x08AA, read 0x09 returns 0x000A.
REQ-035 rsp_valid=1, rsp_data=0x1234; read 0x08 -> mc_data_o=0x1234, mc_data_oe high during oe low, one rsp_ready pulse at oe release.
REQ-036 rsp_valid=0, read 0x08 -> data 0, no rsp_ready, unf set; write 0x09 -> read 0x09 returns 0x0000.
REQ-037 Assert reset during we low after 0x02=0xBEEF setup -> all outputs 0, write not performed, next clean write succeeds.

Source files
------------

// File: rtl/mc_bus_responder.sv
// Asynchronous MCU bus slave: synchronizes the MCU strobes into the clock domain and exposes
// seven config registers, a command stream (0x07), a response stream (0x08) and status (0x09).
module mc_bus_responder #(
   parameter int MC_DATA_WIDTH = 16,
   parameter int MC_ADD_WIDTH  = 6
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       mc_ce,
   input  logic                       mc_we,
   input  logic                       mc_oe,
   input  logic [MC_ADD_WIDTH-1:0]    mc_add,
   input  logic [MC_DATA_WIDTH-1:0]   mc_data_i,
   output logic [MC_DATA_WIDTH-1:0]   mc_data_o,
   output logic                       mc_data_oe,
   output logic [7*MC_DATA_WIDTH-1:0] cfg_regs,
   output logic [MC_DATA_WIDTH-1:0]   cmd_data,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   input  logic [MC_DATA_WIDTH-1:0]   rsp_data,
   input  logic                       rsp_valid,
   output logic                       rsp_ready
);

   localparam int W = MC_DATA_WIDTH;
   localparam logic [MC_ADD_WIDTH-1:0] ADDR_LAST_CFG = MC_ADD_WIDTH'(6);
   localparam logic [MC_ADD_WIDTH-1:0] ADDR_CMD      = MC_ADD_WIDTH'(7);
   localparam logic [MC_ADD_WIDTH-1:0] ADDR_RSP      = MC_ADD_WIDTH'(8);
   localparam logic [MC_ADD_WIDTH-1:0] ADDR_STATUS   = MC_ADD_WIDTH'(9);

   logic [1:0]              r_ce_s;
   logic [1:0]              r_we_s;
   logic [1:0]              r_oe_s;
   logic [MC_ADD_WIDTH-1:0] r_add_s1;
   logic [MC_ADD_WIDTH-1:0] r_add_s2;
   logic [W-1:0]            r_dat_s1;
   logic [W-1:0]            r_dat_s2;
   logic                    r_we_d;
   logic                    r_oe_d;
   logic [1:0]              r_settle;
   logic                    r_we_arm;
   logic                    r_oe_arm;
   logic                    r_rd_act;

   logic [W-1:0]            r_cfg [0:6];
   logic [W-1:0]            r_cmd_data;
   logic                    r_cmd_valid;
   logic                    r_ovf;
   logic                    r_unf;
   logic                    r_rsp_ready;
   logic [W-1:0]            r_data_o;
   logic                    r_data_oe;

   logic                    w_ce;
   logic                    w_we;
   logic                    w_oe;
   logic [MC_ADD_WIDTH-1:0] w_add;
   logic [W-1:0]            w_dat;
   logic                    w_wr_stb;
   logic                    w_rd_start;
   logic                    w_rd_end;
   logic                    w_pop_req;
   logic                    w_is_cfg;
   logic [W-1:0]            w_rd_mux;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ce_s   <= 2'b11;
         r_we_s   <= 2'b11;
         r_oe_s   <= 2'b11;
         r_add_s1 <= '0;
         r_add_s2 <= '0;
         r_dat_s1 <= '0;
         r_dat_s2 <= '0;
      end else begin
         r_ce_s   <= {r_ce_s[0], mc_ce};
         r_we_s   <= {r_we_s[0], mc_we};
         r_oe_s   <= {r_oe_s[0], mc_oe};
         r_add_s1 <= mc_add;
         r_add_s2 <= r_add_s1;
         r_dat_s1 <= mc_data_i;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_ce  = r_ce_s[1];
   assign w_we  = r_we_s[1];
   assign w_oe  = r_oe_s[1];
   assign w_add = r_add_s2;
   assign w_dat = r_dat_s2;

   // A strobe held low through reset must not count as an edge: the arms only set once the
   // synchronizers carry post-reset pin samples showing the idle level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_settle <= 2'd0;
         r_we_arm <= 1'b0;
         r_oe_arm <= 1'b0;
         r_we_d   <= 1'b1;
         r_oe_d   <= 1'b1;
      end else begin
         if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
         if (r_settle == 2'd2 && w_we) r_we_arm <= 1'b1;
         if (r_settle == 2'd2 && w_oe) r_oe_arm <= 1'b1;
         r_we_d <= w_we;
         r_oe_d <= w_oe;
      end
   end

   assign w_wr_stb   = r_we_arm && r_we_d && !w_we && !w_ce;
   assign w_rd_start = r_oe_arm && r_oe_d && !w_oe && !w_ce && w_we;
   assign w_rd_end   = r_rd_act && !r_oe_d && w_oe && !w_ce;
   assign w_pop_req  = w_rd_end && (w_add == ADDR_RSP);
   assign w_is_cfg   = (w_add <= ADDR_LAST_CFG);

   // A read stays open only while chip enable is held and no write overlaps it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_act <= 1'b0;
      end else if (w_ce || !w_we) begin
         r_rd_act <= 1'b0;
      end else if (w_rd_start) begin
         r_rd_act <= 1'b1;
      end else if (w_rd_end) begin
         r_rd_act <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 7; i++) r_cfg[i] <= '0;
         r_cmd_data  <= '0;
         r_cmd_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_rsp_ready <= 1'b0;
      end else begin
         if (r_cmd_valid && cmd_ready) r_cmd_valid <= 1'b0;
         if (w_wr_stb && w_is_cfg) r_cfg[w_add[2:0]] <= w_dat;
         if (w_wr_stb && w_add == ADDR_STATUS) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
         end
         // Later assignments win, so the set paths override the status clear.
         if (w_wr_stb && w_add == ADDR_CMD) begin
            if (r_cmd_valid) begin
               r_ovf <= 1'b1;
            end else begin
               r_cmd_data  <= w_dat;
               r_cmd_valid <= 1'b1;
            end
         end
         if (w_pop_req && !rsp_valid) r_unf <= 1'b1;
         r_rsp_ready <= w_pop_req && rsp_valid;
      end
   end

   always_comb begin
      w_rd_mux = '0;
      if (w_is_cfg) begin
         w_rd_mux = r_cfg[w_add[2:0]];
      end else if (w_add == ADDR_CMD) begin
         w_rd_mux = r_cmd_data;
      end else if (w_add == ADDR_RSP) begin
         w_rd_mux = rsp_valid ? rsp_data : '0;
      end else if (w_add == ADDR_STATUS) begin
         w_rd_mux = {{(W-4){1'b0}}, r_ovf, r_unf, r_cmd_valid, rsp_valid};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_data_o  <= '0;
         r_data_oe <= 1'b0;
      end else begin
         r_data_o  <= w_rd_mux;
         r_data_oe <= r_oe_arm && !w_ce && !w_oe && w_we;
      end
   end

   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_cfg_out
         assign cfg_regs[gi*W +: W] = r_cfg[gi];
      end
   endgenerate

   assign cmd_data   = r_cmd_data;
   assign cmd_valid  = r_cmd_valid;
   assign rsp_ready  = r_rsp_ready;
   assign mc_data_o  = r_data_o;
   assign mc_data_oe = r_data_oe;

endmodule

// File: tb/tb_mc_bus_responder.sv
// Randomized scoreboard bench for mc_bus_responder: MCU bus tasks feed a register-level
// reference model; a negedge monitor checks command handshakes, read data and response pops.
module tb_mc_bus_responder;

   localparam int W = 16;
   localparam int A = 6;

   logic           clock = 1'b0;
   logic           reset;
   logic           mc_ce, mc_we, mc_oe;
   logic [A-1:0]   mc_add;
   logic [W-1:0]   mc_data_i;
   logic [W-1:0]   mc_data_o;
   logic           mc_data_oe;
   logic [7*W-1:0] cfg_regs;
   logic [W-1:0]   cmd_data;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [W-1:0]   rsp_data = '0;
   logic           rsp_valid = 1'b0;
   logic           rsp_ready;

   always #5 clock = ~clock;

   mc_bus_responder #(.MC_DATA_WIDTH(W), .MC_ADD_WIDTH(A)) dut (
      .clock(clock), .reset(reset),
      .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
      .mc_add(mc_add), .mc_data_i(mc_data_i),
      .mc_data_o(mc_data_o), .mc_data_oe(mc_data_oe),
      .cfg_regs(cfg_regs),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
   );

   int n_checks = 0;
   int n_err    = 0;

   // reference model state
   logic [W-1:0] m_cfg [7];
   logic [W-1:0] m_cmd_data;
   logic         m_cmd_pend;
   logic         m_ovf, m_unf;
   logic [W-1:0] rsp_fifo[$];
   logic [W-1:0] rsp_push_q[$];
   logic [W-1:0] exp_cmd_q[$];
   logic [W-1:0] exp_rd_q[$];
   logic [W-1:0] exp_pop_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end else begin
         $display("ok   %s value=%h", nm, act);
      end
   endtask

   task automatic unexpected(input string nm, input logic [31:0] act);
      n_checks++;
      n_err++;
      $display("FAIL %s actual=%h required=no_event", nm, act);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 7; i++) m_cfg[i] = '0;
      m_cmd_data = '0;
      m_cmd_pend = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endfunction

   function automatic logic [W-1:0] model_read(input int a);
      if (a < 7) return m_cfg[a];
      if (a == 7) return m_cmd_data;
      if (a == 8) return (rsp_fifo.size() > 0) ? rsp_fifo[0] : '0;
      if (a == 9) return {12'h000, m_ovf, m_unf, m_cmd_pend, rsp_fifo.size() > 0};
      return '0;
   endfunction

   function automatic void model_write(input int a, input logic [W-1:0] d);
      if (a < 7) begin
         m_cfg[a] = d;
      end else if (a == 7) begin
         if (m_cmd_pend) begin
            m_ovf = 1'b1;
         end else begin
            m_cmd_data = d;
            m_cmd_pend = 1'b1;
            exp_cmd_q.push_back(d);
         end
      end else if (a == 9) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
   endfunction

   // monitor: owns the response FIFO presented to the DUT and compares every DUT event
   logic         mon_oe_prev = 1'b0;
   logic [W-1:0] mon_last_rd = '0;
   always @(negedge clock) begin
      if (cmd_valid && cmd_ready) begin
         if (exp_cmd_q.size() == 0) unexpected("cmd_handshake", 32'(cmd_data));
         else check("cmd_data", 32'(cmd_data), 32'(exp_cmd_q.pop_front()));
      end
      if (mc_data_oe) begin
         mon_last_rd = mc_data_o;
         mon_oe_prev = 1'b1;
      end else if (mon_oe_prev) begin
         mon_oe_prev = 1'b0;
         if (exp_rd_q.size() == 0) unexpected("read_cycle", 32'(mon_last_rd));
         else check("read_data", 32'(mon_last_rd), 32'(exp_rd_q.pop_front()));
      end
      if (rsp_ready) begin
         if (exp_pop_q.size() == 0) unexpected("rsp_pop", 32'(rsp_data));
         else check("rsp_pop", 32'(rsp_data), 32'(exp_pop_q.pop_front()));
         if (rsp_fifo.size() > 0) void'(rsp_fifo.pop_front());
      end
      while (rsp_push_q.size() > 0) rsp_fifo.push_back(rsp_push_q.pop_front());
      rsp_valid = (rsp_fifo.size() > 0);
      rsp_data  = (rsp_fifo.size() > 0) ? rsp_fifo[0] : '0;
   end

   task automatic rsp_push(input logic [W-1:0] v);
      rsp_push_q.push_back(v);
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic mcu_write(input int a, input logic [W-1:0] d, input logic with_oe);
      model_write(a, d);
      @(posedge clock); #1;
      mc_add = A'(a); mc_data_i = d; mc_ce = 1'b0; mc_we = 1'b0;
      if (with_oe) mc_oe = 1'b0;
      repeat (6) @(posedge clock);
      #1 mc_we = 1'b1; mc_oe = 1'b1; mc_ce = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      if (cmd_ready) m_cmd_pend = 1'b0;
   endtask

   task automatic mcu_read(input int a, input logic ce_early);
      exp_rd_q.push_back(model_read(a));
      if (a == 8 && !ce_early) begin
         if (rsp_fifo.size() > 0) exp_pop_q.push_back(rsp_fifo[0]);
         else m_unf = 1'b1;
      end
      @(posedge clock); #1;
      mc_add = A'(a); mc_ce = 1'b0; mc_oe = 1'b0;
      repeat (6) @(posedge clock);
      #1 mc_oe = 1'b1;
      if (ce_early) mc_ce = 1'b1;
      repeat (4) @(posedge clock);
      #1 mc_ce = 1'b1;
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic check_cfg(input string nm);
      for (int i = 0; i < 7; i++)
         check($sformatf("%s_w%0d", nm, i), 32'(cfg_regs[i*W +: W]), 32'(m_cfg[i]));
   endtask

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int width;
      model_reset();
      reset = 1'b1; mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
      mc_add = '0; mc_data_i = '0; cmd_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_cfg", 32'(cfg_regs == '0), 32'd1);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_data_oe", 32'(mc_data_oe), 32'd0);
      check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
      check("rst_data_o", 32'(mc_data_o), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;

      // config register writes
      mcu_write(0, 16'h00FB, 1'b0);
      mcu_write(1, 16'h0004, 1'b0);
      mcu_write(3, 16'h0080, 1'b0);
      check_cfg("cfg");

      // command write latency and single-cycle valid
      cmd_ready = 1'b1;
      model_write(7, 16'h08AA);
      @(posedge clock); #1;
      mc_add = A'(7); mc_data_i = 16'h08AA; mc_ce = 1'b0; mc_we = 1'b0;
      k = 0; width = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clock); #1;
         if (cmd_valid) begin
            width++;
            if (k == 0) k = i;
         end
      end
      check("cmd_latency", 32'(k), 32'd3);
      check("cmd_valid_width", 32'(width), 32'd1);
      mc_we = 1'b1; mc_ce = 1'b1;
      repeat (3) @(posedge clock); #1;
      m_cmd_pend = 1'b0;

      // overflow when the command stream is stalled
      cmd_ready = 1'b0;
      mcu_write(7, 16'h08AA, 1'b0);
      mcu_write(7, 16'h08FF, 1'b0);
      check("cmd_hold", 32'(cmd_data), 32'h08AA);
      mcu_read(9, 1'b0);
      cmd_ready = 1'b1;
      repeat (3) @(posedge clock); #1;
      m_cmd_pend = 1'b0;
      mcu_write(9, 16'hFFFF, 1'b0);
      mcu_read(9, 1'b0);

      // response pop, underflow and clear
      rsp_push(16'h1234);
      mcu_read(8, 1'b0);
      mcu_read(8, 1'b0);
      mcu_read(9, 1'b0);
      mcu_write(9, 16'h0000, 1'b0);
      mcu_read(9, 1'b0);

      // overlapping write+read is a write only; chip enable released early suppresses pop
      rsp_push(16'h5A5A);
      mcu_write(8, 16'hDEAD, 1'b1);
      mcu_read(8, 1'b0);
      rsp_push(16'h7777);
      mcu_read(8, 1'b1);
      mcu_read(8, 1'b0);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 2))
            0: if (rsp_fifo.size() < 4) rsp_push(16'($urandom));
            1: mcu_write(int'($urandom_range(0, 11)), 16'($urandom), 1'b0);
            default: mcu_read(int'($urandom_range(0, 11)), 1'b0);
         endcase
      end
      check_cfg("rand_cfg");

      // reset in the middle of a write aborts it
      @(posedge clock); #1;
      mc_add = A'(2); mc_data_i = 16'hBEEF; mc_ce = 1'b0; mc_we = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      model_reset();
      @(posedge clock); #1;
      check("mid_rst_cfg", 32'(cfg_regs == '0), 32'd1);
      check("mid_rst_cmd", 32'({cmd_valid, cmd_data}), 32'd0);
      check("mid_rst_rd", 32'({mc_data_oe, mc_data_o, rsp_ready}), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (5) @(posedge clock);
      #1 mc_we = 1'b1; mc_ce = 1'b1;
      repeat (3) @(posedge clock); #1;
      check("rst_abort_w2", 32'(cfg_regs[2*W +: W]), 32'h0000);
      mcu_write(2, 16'hBEEF, 1'b0);
      check("post_rst_w2", 32'(cfg_regs[2*W +: W]), 32'hBEEF);
      mcu_read(9, 1'b0);

      repeat (5) @(posedge clock); #1;
      check("cmd_q_left", 32'(exp_cmd_q.size()), 32'd0);
      check("rd_q_left", 32'(exp_rd_q.size()), 32'd0);
      check("pop_q_left", 32'(exp_pop_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
